// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, requests words from instruction
// memory, holds each fetched word for decode and applies branch/jump redirects.
module fetch_sequencer #(
    parameter int ADDR_W   = 7,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       dec_instr_q, dec_instr_d;
    logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
    logic              dec_valid_q, dec_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= PC_RST;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            dec_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_valid_q <= dec_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_valid_d = dec_valid_q;
        fetch_err_d = fetch_err_q;
        if (state_q != ERR) begin
            // Redirect outranks any concurrent ack or decode handshake.
            if (redirect) begin
                dec_valid_d = 1'b0;
                if (redirect_aligned) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else begin
                    fetch_err_d = 1'b1;
                    state_d     = ERR;
                end
            end else begin
                case (state_q)
                    IDLE: state_d = FETCH;
                    FETCH: begin
                        if (imem_ack) begin
                            dec_instr_d = imem_data;
                            dec_pc_d    = pc_q;
                            pc_d        = pc_q + PC_STEP;
                            dec_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                    HOLD: begin
                        if (dec_ready) begin
                            dec_valid_d = 1'b0;
                            state_d     = FETCH;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if (state_q == FETCH) imem_req = 1'b1;
    end

    assign imem_addr = pc_q;
    assign dec_valid = dec_valid_q;
    assign dec_instr = dec_instr_q;
    assign dec_pc    = dec_pc_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, checked
// every cycle against a rule-level model of the fetch/hold/redirect behaviour.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [6:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [6:0]  dec_pc;
    logic        redirect;
    logic [6:0]  redirect_pc;
    logic        fetch_err;
    logic        ack_in;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [128];

    // Model: where fetch stands, expressed as plain facts rather than states.
    bit         m_started;
    bit         m_have;
    bit         m_dead;
    int         m_pc;
    int         m_dpc;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    assign imem_ack  = ack_in & imem_req;
    assign imem_data = {mem[imem_addr], mem[imem_addr + 7'd1],
                        mem[imem_addr + 7'd2], mem[imem_addr + 7'd3]};

    fetch_sequencer #(.ADDR_W(7), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err)
    );

    function automatic logic [31:0] word_at(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_have = 0; m_dead = 0;
        m_pc = 0; m_dpc = 0; m_instr = '0;
    endtask

    task automatic model_step(input bit r, input int rp, input bit a, input bit d);
        if (m_dead) return;
        if (r) begin
            m_have = 0;
            if (rp % 4 == 0) begin
                m_pc = rp; m_started = 1;
            end else begin
                m_dead = 1;
            end
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_have) begin
            if (d) m_have = 0;
        end else if (a) begin
            m_instr = word_at(m_pc);
            m_dpc   = m_pc;
            m_pc    = (m_pc + 4) % 128;
            m_have  = 1;
        end
    endtask

    task automatic compare_all();
        check("imem_req", {31'd0, imem_req}, {31'd0, m_started && !m_have && !m_dead});
        check("imem_addr", {25'd0, imem_addr}, m_pc);
        check("dec_valid", {31'd0, dec_valid}, {31'd0, m_have});
        check("fetch_err", {31'd0, fetch_err}, {31'd0, m_dead});
        if (m_have) begin
            check("dec_instr", dec_instr, m_instr);
            check("dec_pc", {25'd0, dec_pc}, m_dpc);
        end
    endtask

    // One clock: drive inputs, compare, advance model, land on next negedge.
    task automatic cyc(input bit r, input int rp, input bit a, input bit d);
        redirect = r; redirect_pc = 7'(rp); ack_in = a; dec_ready = d;
        #1;
        compare_all();
        model_step(r, rp, a, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 7'd40; ack_in = 1'b1; dec_ready = 1'b1;
        #1;
        model_reset();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", {25'd0, imem_addr}, 32'd0);
        check("rst_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_instr", dec_instr, 32'd0);
        check("rst_dpc", {25'd0, dec_pc}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_dominates", {25'd0, imem_addr}, 32'd0);
        rst_n = 1'b1; redirect = 1'b0;
    endtask

    initial begin
        int seq_k;
        int wrap_k;
        bit r;
        int rp;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        rst_n = 1'b1; redirect = 0; redirect_pc = 0; ack_in = 0; dec_ready = 0;
        @(negedge clk);
        do_reset();

        // Streaming from reset with a zero-latency memory.
        seq_k = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 1) check("first_req", {31'd0, imem_req}, 32'd1);
            if (dec_valid) begin
                check("seq_pc", {25'd0, dec_pc}, seq_k * 4);
                check("seq_instr", dec_instr, word_at(seq_k * 4));
                seq_k++;
            end
            cyc(0, 0, 1, 1);
        end
        check("seq_count", seq_k, 32'd4);

        // Wrap-around from the top word.
        cyc(1, 124, 0, 0);
        wrap_k = 0;
        for (int i = 0; i < 4; i++) begin
            if (dec_valid) begin
                check("wrap_pc", {25'd0, dec_pc}, (wrap_k == 0) ? 124 : 0);
                wrap_k++;
            end
            cyc(0, 0, 1, 1);
        end
        check("wrap_count", wrap_k, 32'd2);

        // Decode stall for five cycles.
        cyc(1, 20, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_pc", {25'd0, dec_pc}, 32'd20);
            check("stall_instr", dec_instr, word_at(20));
            cyc(0, 0, 0, 0);
        end
        cyc(0, 0, 0, 1);
        check("after_stall_addr", {25'd0, imem_addr}, 32'd24);

        // Memory answering after three wait cycles.
        for (int i = 0; i < 3; i++) begin
            check("lat_req", {31'd0, imem_req}, 32'd1);
            check("lat_addr", {25'd0, imem_addr}, 32'd24);
            cyc(0, 0, 0, 0);
        end
        cyc(0, 0, 1, 0);
        check("lat_dpc", {25'd0, dec_pc}, 32'd24);
        check("lat_pc_once", {25'd0, imem_addr}, 32'd28);

        // Redirect colliding with a decode accept, then with a memory ack.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 40, 0, 1);
        check("coll_hold_valid", {31'd0, dec_valid}, 32'd0);
        check("coll_hold_addr", {25'd0, imem_addr}, 32'd40);
        cyc(1, 40, 1, 0);
        check("coll_fetch_valid", {31'd0, dec_valid}, 32'd0);
        check("coll_fetch_addr", {25'd0, imem_addr}, 32'd40);

        // Random traffic with aligned redirects.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 11) == 0);
            rp = 4 * $urandom_range(0, 31);
            cyc(r, rp, 1'($urandom), 1'($urandom));
        end

        // Reset abandoning an outstanding request, then one abandoning a held word.
        cyc(1, 60, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        check("hold_before_rst", {31'd0, dec_valid}, 32'd1);
        do_reset();

        // Misaligned redirect is terminal until reset.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
        cyc(1, 42, 1, 1);
        check("err_set", {31'd0, fetch_err}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            rp = $urandom_range(0, 127);
            cyc(1'($urandom), rp, 1'($urandom), 1'($urandom));
        end
        check("err_sticky", {31'd0, fetch_err}, 32'd1);
        check("err_no_req", {31'd0, imem_req}, 32'd0);
        do_reset();
        check("err_cleared", {31'd0, fetch_err}, 32'd0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        check("restart_dpc", {25'd0, dec_pc}, 32'd0);
        for (int i = 0; i < 40; i++) cyc(0, 0, 1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
